// File: rtl/kernel_buffer_loader_pkg.sv
// Shared definitions for the kernel buffer write-side loader.
// Holds the io bus field layout helpers and the loader FSM state encoding.
// Field positions are functions of (W, depth) so every module derives identical offsets.
package kernel_buffer_loader_pkg;

    // Loader FSM states: waiting for start, accepting words, final write in flight.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LAST = 2'd2
    } state_t;

    // Default geometry of the kernel buffer.
    localparam int DEF_DEPTH = 2;
    localparam int DEF_A     = 7;
    localparam int DEF_W     = 16;

    // io bus layout: {ioSelect, ioWrite, ioBankSelect[depth], data[W]}.
    localparam int IO_DATA_LSB = 0;

    function automatic int io_width(input int w, input int depth);
        return w + depth + 2;
    endfunction

    function automatic int io_bank_lsb(input int w);
        return w;
    endfunction

    function automatic int io_write_bit(input int w, input int depth);
        return w + depth;
    endfunction

    function automatic int io_select_bit(input int w, input int depth);
        return w + depth + 1;
    endfunction

endpackage

// File: rtl/kernel_buffer_loader_addr_counter.sv
// Bank/row counter for the loader: captures base and row count, steps bank then row.
// Zero latency on outputs (registered counters, combinational address and last flag).
// No flow control of its own; the loader asserts incr only on an accepted word.
module kbl_addr_counter #(
    parameter int depth = 2,
    parameter int A     = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             incr,
    input  logic [A-1:0]     base_in,
    input  logic [A:0]       rows_in,
    output logic [depth-1:0] bank,
    output logic [A-1:0]     row_addr,
    output logic             last_word
);

    localparam int D = 1 << depth;
    localparam logic [depth-1:0] BANK_MAX = depth'(D - 1);
    localparam logic [depth-1:0] BANK_ONE = depth'(1);
    localparam logic [A:0]       ROW_ONE  = (A+1)'(1);

    logic [A-1:0]     base_q;
    logic [A:0]       rows_q;
    logic [A:0]       row_q;
    logic [depth-1:0] bank_q;

    // Capture load parameters on clear; otherwise advance bank, carrying into row on wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            rows_q <= '0;
            row_q  <= '0;
            bank_q <= '0;
        end else if (clear) begin
            base_q <= base_in;
            rows_q <= rows_in;
            row_q  <= '0;
            bank_q <= '0;
        end else if (incr) begin
            bank_q <= bank_q + BANK_ONE;
            if (bank_q == BANK_MAX) begin
                row_q <= row_q + ROW_ONE;
            end
        end
    end

    // Row address wraps naturally by truncating the sum to A bits.
    always_comb begin
        bank      = bank_q;
        row_addr  = base_q + row_q[A-1:0];
        last_word = (bank_q == BANK_MAX) && (row_q == rows_q - ROW_ONE);
    end

endmodule

// File: rtl/kernel_buffer_loader.sv
// Write-side sequencer: streams W-bit weights into D banks per row from a base address.
// One-cycle latency from accepted word to registered write on the io bus; done one cycle after last write.
// in_ready is high only in LOAD; the stream is stalled in IDLE and during the final write cycle.
module kernel_buffer_loader
    import kernel_buffer_loader_pkg::*;
#(
    parameter int depth = DEF_DEPTH,
    parameter int A     = DEF_A,
    parameter int W     = DEF_W
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 start,
    input  logic [A-1:0]         base_addr,
    input  logic [A:0]           num_rows,
    input  logic [W-1:0]         in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W+depth+1:0]   ioInputs,
    output logic [A-1:0]         address,
    output logic                 busy,
    output logic                 done
);

    localparam int IO_BANK_LSB   = io_bank_lsb(W);
    localparam int IO_WRITE_BIT  = io_write_bit(W, depth);
    localparam int IO_SELECT_BIT = io_select_bit(W, depth);

    state_t state, state_nxt;

    logic             io_sel;
    logic             io_wr;
    logic [depth-1:0] io_bank;
    logic [W-1:0]     io_dat;

    logic             handshake;
    logic             start_acc;
    logic [depth-1:0] cnt_bank;
    logic [A-1:0]     cnt_row_addr;
    logic             cnt_last;

    assign handshake = in_valid & in_ready;
    assign start_acc = (state == ST_IDLE) & start;

    kbl_addr_counter #(
        .depth (depth),
        .A     (A)
    ) u_addr_counter (
        .clk       (CLK),
        .rst_n     (RESETn),
        .clear     (start_acc),
        .incr      (handshake),
        .base_in   (base_addr),
        .rows_in   (num_rows),
        .bank      (cnt_bank),
        .row_addr  (cnt_row_addr),
        .last_word (cnt_last)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero-row start completes without leaving IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && (num_rows != '0)) state_nxt = ST_LOAD;
            ST_LOAD: if (handshake && cnt_last)    state_nxt = ST_LAST;
            ST_LAST:                               state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // Combinational output: accept weights only while loading.
    always_comb begin
        in_ready = (state == ST_LOAD);
    end

    // Registered buffer-side outputs; data/bank/address hold between accepted words.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            io_sel  <= 1'b0;
            io_wr   <= 1'b0;
            io_bank <= '0;
            io_dat  <= '0;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    io_wr <= 1'b0;
                    if (start) begin
                        if (num_rows == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            io_sel <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    io_wr <= handshake;
                    if (handshake) begin
                        io_dat  <= in_data;
                        io_bank <= cnt_bank;
                        address <= cnt_row_addr;
                    end
                end
                ST_LAST: begin
                    io_sel <= 1'b0;
                    io_wr  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    io_sel <= 1'b0;
                    io_wr  <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Pack the io bus fields at their defined offsets.
    always_comb begin
        ioInputs                         = '0;
        ioInputs[IO_SELECT_BIT]          = io_sel;
        ioInputs[IO_WRITE_BIT]           = io_wr;
        ioInputs[IO_BANK_LSB +: depth]   = io_bank;
        ioInputs[IO_DATA_LSB +: W]       = io_dat;
    end

endmodule

// File: tb/tb_kernel_buffer_loader.sv
// Directed bench for kernel_buffer_loader: back-to-back, gapped, zero-row, wrap, reset, start-while-busy.
module tb_kernel_buffer_loader;

    localparam int DEPTH = 2;
    localparam int A     = 7;
    localparam int W     = 16;
    localparam int IOW   = W + DEPTH + 2;
    localparam int SEL   = W + DEPTH + 1;
    localparam int WR    = W + DEPTH;

    logic           CLK;
    logic           RESETn;
    logic           start;
    logic [A-1:0]   base_addr;
    logic [A:0]     num_rows;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [IOW-1:0] ioInputs;
    logic [A-1:0]   address;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [A-1:0]     wr_addr[$];
    logic [DEPTH-1:0] wr_bank[$];
    logic [W-1:0]     wr_data[$];
    int               wr_cyc[$];
    logic [W-1:0]     exp_data[$];
    int               done_cnt = 0;
    int               done_cyc = 0;
    int               sel_cnt  = 0;

    kernel_buffer_loader #(.depth(DEPTH), .A(A), .W(W)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ioInputs  (ioInputs),
        .address   (address),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Log every buffer write and every done pulse, sampled mid-cycle.
    always @(negedge CLK) begin
        if (ioInputs[SEL] && ioInputs[WR]) begin
            wr_addr.push_back(address);
            wr_bank.push_back(ioInputs[W +: DEPTH]);
            wr_data.push_back(ioInputs[W-1:0]);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (ioInputs[SEL]) sel_cnt = sel_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_bank.delete();
        wr_data.delete();
        wr_cyc.delete();
        exp_data.delete();
        done_cnt = 0;
        sel_cnt  = 0;
    endtask

    task automatic do_start(input logic [A-1:0] b, input logic [A:0] n);
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Offer words with in_valid high every 'period' cycles until n are accepted.
    task automatic stream(input int n, input int period, input logic [W-1:0] dbase);
        int k = 0;
        int t = 0;
        while (k < n && t < 200) begin
            in_valid = ((t % period) == 0);
            in_data  = dbase + W'(k);
            if (in_valid && in_ready) begin
                exp_data.push_back(in_data);
                k = k + 1;
            end
            tick();
            t = t + 1;
        end
        in_valid = 1'b0;
        checks++;
        if (k !== n) begin
            errors++;
            $display("FAIL stream_accept: accepted %0d words, required %0d", k, n);
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        tick(); tick(); tick();
        checks++; if (ioInputs !== '0) begin errors++; $display("FAIL reset_io: got %h want 0", ioInputs); end
        checks++; if (address !== '0)  begin errors++; $display("FAIL reset_addr: got %0d want 0", address); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [A-1:0] ea;
        clear_log();
        do_start(7'd5, 8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        checks++; if (ioInputs[SEL] !== 1'b1) begin errors++; $display("FAIL b2b_sel: got %b want 1", ioInputs[SEL]); end
        checks++; if (ioInputs[WR] !== 1'b0) begin errors++; $display("FAIL b2b_wr_idle: got %b want 0", ioInputs[WR]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        stream(8, 1, 16'h1000);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_early: got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
        checks++; if (ioInputs[SEL] !== 1'b0) begin errors++; $display("FAIL b2b_sel_fall: got %b want 0", ioInputs[SEL]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_idle: got %b want 0", in_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b want 0", done); end
        checks++; if (wr_addr.size() !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", wr_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = 7'(5 + i / 4);
            checks++;
            if (wr_addr[i] !== ea || wr_bank[i] !== 2'(i % 4) || wr_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL b2b_write%0d: got a=%0d b=%0d d=%h want a=%0d b=%0d d=%h",
                         i, wr_addr[i], wr_bank[i], wr_data[i], ea, i % 4, exp_data[i]);
            end
        end
        checks++; if (wr_cyc[7] - wr_cyc[0] !== 7) begin errors++; $display("FAIL b2b_consecutive: span %0d want 7", wr_cyc[7] - wr_cyc[0]); end
        checks++; if (done_cyc !== wr_cyc[7] + 1) begin errors++; $display("FAIL b2b_done_time: got %0d want %0d", done_cyc, wr_cyc[7] + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_gapped();
        logic [A-1:0] ea;
        clear_log();
        do_start(7'd5, 8'd2);
        stream(8, 3, 16'h2000);
        tick(); tick();
        checks++; if (wr_addr.size() !== 8) begin errors++; $display("FAIL gap_count: got %0d want 8", wr_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = 7'(5 + i / 4);
            checks++;
            if (wr_addr[i] !== ea || wr_bank[i] !== 2'(i % 4) || wr_data[i] !== 16'(16'h2000 + i)) begin
                errors++;
                $display("FAIL gap_write%0d: got a=%0d b=%0d d=%h want a=%0d b=%0d d=%h",
                         i, wr_addr[i], wr_bank[i], wr_data[i], ea, i % 4, 16'h2000 + i);
            end
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (wr_cyc[i+1] - wr_cyc[i] !== 3) begin
                errors++;
                $display("FAIL gap_spacing%0d: got %0d want 3", i, wr_cyc[i+1] - wr_cyc[i]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL gap_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_rows();
        clear_log();
        do_start(7'd9, 8'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %b want 0", in_ready); end
        in_valid = 1'b1;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
        tick(); tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_late: got %b want 0", busy); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
        checks++; if (sel_cnt !== 0) begin errors++; $display("FAIL zero_sel: got %0d want 0", sel_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [A-1:0] ea;
        clear_log();
        do_start(7'd126, 8'd3);
        stream(12, 1, 16'h3000);
        tick(); tick();
        checks++; if (wr_addr.size() !== 12) begin errors++; $display("FAIL wrap_count: got %0d want 12", wr_addr.size()); end
        for (int i = 0; i < 12; i++) begin
            ea = (i < 4) ? 7'd126 : (i < 8) ? 7'd127 : 7'd0;
            checks++;
            if (wr_addr[i] !== ea || wr_bank[i] !== 2'(i % 4) || wr_data[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL wrap_write%0d: got a=%0d b=%0d d=%h want a=%0d b=%0d d=%h",
                         i, wr_addr[i], wr_bank[i], wr_data[i], ea, i % 4, exp_data[i]);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        clear_log();
        do_start(7'd20, 8'd2);
        stream(3, 1, 16'h4000);
        RESETn = 1'b0;
        tick();
        checks++; if (ioInputs !== '0) begin errors++; $display("FAIL mrst_io: got %h want 0", ioInputs); end
        checks++; if (address !== '0) begin errors++; $display("FAIL mrst_addr: got %0d want 0", address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b want 0", done); end
        RESETn = 1'b1;
        tick(); tick();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mrst_no_done: got %0d want 0", done_cnt); end
        clear_log();
        do_start(7'd40, 8'd1);
        stream(4, 1, 16'h5000);
        tick(); tick();
        checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL mrst_new_count: got %0d want 4", wr_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== 7'd40 || wr_bank[i] !== 2'(i) || wr_data[i] !== 16'(16'h5000 + i)) begin
                errors++;
                $display("FAIL mrst_new_write%0d: got a=%0d b=%0d d=%h want a=40 b=%0d d=%h",
                         i, wr_addr[i], wr_bank[i], wr_data[i], i, 16'h5000 + i);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mrst_new_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy();
        logic [A-1:0] ea;
        clear_log();
        do_start(7'd10, 8'd2);
        stream(3, 1, 16'h6000);
        base_addr = 7'd99;
        num_rows  = 8'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_busy: got %b want 1", busy); end
        stream(5, 1, 16'h6003);
        tick(); tick(); tick();
        checks++; if (wr_addr.size() !== 8) begin errors++; $display("FAIL swb_count: got %0d want 8", wr_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            ea = 7'(10 + i / 4);
            checks++;
            if (wr_addr[i] !== ea || wr_bank[i] !== 2'(i % 4) || wr_data[i] !== 16'(16'h6000 + i)) begin
                errors++;
                $display("FAIL swb_write%0d: got a=%0d b=%0d d=%h want a=%0d b=%0d d=%h",
                         i, wr_addr[i], wr_bank[i], wr_data[i], ea, i % 4, 16'h6000 + i);
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL swb_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        RESETn    = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_zero_rows();
        test_wrap();
        test_mid_reset();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
